// File: rtl/ciclo_pkg.sv
// Shared definitions for the ciclo sequencer: state encodings, mode constants
// and default widths.
package ciclo_pkg;

  localparam int TICK_W_DEF = 5;
  localparam int CYC_W_DEF  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } estado_t;

  localparam logic MODO_UNO  = 1'b0;
  localparam logic MODO_LAZO = 1'b1;

endpackage

// File: rtl/ciclo_prescaler.sv
// Clearable per-step clock counter; wraps to zero after matching the latched
// period and flags that wrap with a strobe.
module ciclo_prescaler
  import ciclo_pkg::*;
#(
  parameter int TICK_W = TICK_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              run,
  input  logic [TICK_W-1:0] per,
  output logic [TICK_W-1:0] cuenta,
  output logic              wrap
);

  logic [TICK_W-1:0] cuenta_r;
  logic              fin_s;

  assign fin_s  = (cuenta_r == per);
  assign wrap   = run && !clr && fin_s;
  assign cuenta = cuenta_r;

  // Clock count within the current step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cuenta_r <= {TICK_W{1'b0}};
    end else if (clr) begin
      cuenta_r <= {TICK_W{1'b0}};
    end else if (run) begin
      cuenta_r <= fin_s ? {TICK_W{1'b0}} : cuenta_r + TICK_W'(1);
    end
  end

endmodule

// File: rtl/ciclo_secuenciador.sv
// Step sequencer: FSM, latched configuration and step index. Optional pause
// input and PAUSE state are compiled in with CICLO_SECUENCIADOR_PAUSA_EN.
module ciclo_secuenciador
  import ciclo_pkg::*;
#(
  parameter int TICK_W = TICK_W_DEF,
  parameter int CYC_W  = CYC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  input  logic              stop,
  input  logic [TICK_W-1:0] periodo,
  input  logic [CYC_W-1:0]  duracion,
  input  logic              modo,
`ifdef CICLO_SECUENCIADOR_PAUSA_EN
  input  logic              pausa,
`endif
  output logic [CYC_W-1:0]  ciclo,
  output logic [TICK_W-1:0] cuenta,
  output logic              tick,
  output logic              done,
  output logic              busy
);

  estado_t           estado_r;
  logic [TICK_W-1:0] per_r;
  logic [CYC_W-1:0]  dur_r;
  logic              modo_r;
  logic [CYC_W-1:0]  ciclo_r;
  logic              tick_r;
  logic              done_r;

  logic              pausa_s;
  logic              arranque_s;
  logic              clr_s;
  logic              run_s;
  logic              wrap_s;
  logic [CYC_W:0]    dur_m1_s;
  logic              ultimo_s;

`ifdef CICLO_SECUENCIADOR_PAUSA_EN
  assign pausa_s = pausa;
`else
  assign pausa_s = 1'b0;
`endif

  assign arranque_s = start && (duracion != {CYC_W{1'b0}});
  assign clr_s      = !en || stop || arranque_s || (estado_r == ST_IDLE);
  // Pausing gates the counter directly, so each paused clock costs exactly one clock
  assign run_s      = (estado_r != ST_IDLE) && !pausa_s;
  assign dur_m1_s   = {1'b0, dur_r} - {{CYC_W{1'b0}}, 1'b1};
  assign ultimo_s   = ({1'b0, ciclo_r} == dur_m1_s);

  ciclo_prescaler #(.TICK_W(TICK_W)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr_s),
    .run    (run_s),
    .per    (per_r),
    .cuenta (cuenta),
    .wrap   (wrap_s)
  );

  // Sequencer FSM, configuration latch, step index and strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_r <= ST_IDLE;
      per_r    <= {TICK_W{1'b0}};
      dur_r    <= {CYC_W{1'b0}};
      modo_r   <= MODO_UNO;
      ciclo_r  <= {CYC_W{1'b0}};
      tick_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (!en || stop) begin
      estado_r <= ST_IDLE;
      ciclo_r  <= {CYC_W{1'b0}};
      tick_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (arranque_s) begin
      estado_r <= ST_RUN;
      per_r    <= periodo;
      dur_r    <= duracion;
      modo_r   <= modo;
      ciclo_r  <= {CYC_W{1'b0}};
      tick_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      done_r <= 1'b0;
      case (estado_r)
        ST_RUN, ST_PAUSE: begin
          estado_r <= pausa_s ? ST_PAUSE : ST_RUN;
          if (wrap_s) begin
            tick_r <= 1'b1;
            if (ultimo_s) begin
              done_r  <= 1'b1;
              ciclo_r <= {CYC_W{1'b0}};
              if (modo_r == MODO_UNO) begin
                estado_r <= ST_IDLE;
              end
            end else begin
              ciclo_r <= ciclo_r + CYC_W'(1);
            end
          end
        end
        default: begin
          estado_r <= ST_IDLE;
          ciclo_r  <= {CYC_W{1'b0}};
        end
      endcase
    end
  end

  assign ciclo = ciclo_r;
  assign tick  = tick_r;
  assign done  = done_r;
  assign busy  = (estado_r != ST_IDLE);

endmodule
